// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its downstream stages.
//   STAT_*          bit indices into the 4-bit status word
//   arith_status_t  packed view of the status word
//   fill_state_e    occupancy class of the result FIFO
//   fill_state()    maps a level to its occupancy class
package arith_pkg;

  localparam int unsigned STAT_ERROR = 3;
  localparam int unsigned STAT_NEZ   = 2;
  localparam int unsigned STAT_ZEROS = 1;
  localparam int unsigned STAT_OVF   = 0;
  localparam int unsigned STAT_W     = 4;

  typedef struct packed {
    logic error;
    logic nez;
    logic zeros;
    logic ovf;
  } arith_status_t;

  typedef enum logic [1:0] {
    FillEmpty,
    FillPartial,
    FillFull
  } fill_state_e;

  function automatic fill_state_e fill_state(input int unsigned level, input int unsigned depth);
    fill_state_e st;
    if (level == 0) begin
      st = FillEmpty;
    end else if (level >= depth) begin
      st = FillFull;
    end else begin
      st = FillPartial;
    end
    return st;
  endfunction

endpackage

// File: rtl/arith_fifo_mem.sv
// Register-array storage for the result FIFO.
//   i_clk    clock, write on rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (asynchronous read)
//   o_rdata  read data
// Contents are intentionally not reset.
module arith_fifo_mem #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/arith_result_buffer.sv
// Result FIFO behind the arithmetic unit with valid/ready output and status counters.
//   i_clk, i_reset_n    clock and asynchronous active-low reset
//   i_clear             synchronous clear of FIFO, counters and drop flag
//   i_valid, i_result,
//   i_status            registered ALU output and its status word
//   i_filter_err        discard (but still count) results flagged ERROR
//   i_ready, o_valid,
//   o_result, o_status  first-word-fall-through consumer handshake
//   o_level, o_full     occupancy
//   o_drop              sticky: an input was lost to a full FIFO
//   o_err_cnt,
//   o_zero_cnt          saturating counts of ERROR / ZEROS inputs
module arith_result_buffer
  import arith_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic [BITS-1:0]            i_result,
  input  logic [3:0]                 i_status,
  input  logic                       i_filter_err,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [BITS-1:0]            o_result,
  output logic [3:0]                 o_status,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_drop,
  output logic [CNT_W-1:0]           o_err_cnt,
  output logic [CNT_W-1:0]           o_zero_cnt
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LvlW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = BITS + STAT_W;

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  zero_cnt_q, zero_cnt_d;
  // Last value shown on the output, so data holds (and is never X) while empty.
  logic [EntryW-1:0] hold_q, hold_d;

  arith_status_t     in_stat;
  fill_state_e       fill;
  logic              head_valid;
  logic              full;
  logic              pop;
  logic              store;
  logic              push;
  logic              lost;
  logic              mem_we;
  logic [EntryW-1:0] head_entry;
  logic [EntryW-1:0] out_entry;

  assign in_stat    = arith_status_t'(i_status);
  assign fill       = fill_state(32'(level_q), DEPTH);
  assign head_valid = (fill != FillEmpty);
  assign full       = (fill == FillFull);

  assign pop   = head_valid & i_ready;
  assign store = i_valid & ~(i_filter_err & in_stat.error);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push  = store & (~full | pop);
  assign lost  = store & full & ~pop;

  assign mem_we    = push & ~i_clear;
  assign out_entry = head_valid ? head_entry : hold_q;

  arith_fifo_mem #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata ({i_status, i_result}),
    .i_raddr (rd_ptr_q),
    .o_rdata (head_entry)
  );

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    drop_d     = drop_q;
    err_cnt_d  = err_cnt_q;
    zero_cnt_d = zero_cnt_q;
    hold_d     = out_entry;

    if (i_clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      drop_d     = 1'b0;
      err_cnt_d  = '0;
      zero_cnt_d = '0;
      hold_d     = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
      if (lost) begin
        drop_d = 1'b1;
      end
      // Counters see every valid input, even ones filtered or lost.
      if (i_valid && in_stat.error && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (i_valid && in_stat.zeros && (zero_cnt_q != '1)) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= 1'b0;
      err_cnt_q  <= '0;
      zero_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      err_cnt_q  <= err_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign o_valid    = head_valid;
  assign o_result   = out_entry[BITS-1:0];
  assign o_status   = out_entry[EntryW-1 -: STAT_W];
  assign o_level    = level_q;
  assign o_full     = full;
  assign o_drop     = drop_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_zero_cnt = zero_cnt_q;

endmodule
